// File: rtl/multi_edge_pkg.sv
// Shared types for the multi-channel edge detector.
// Mode encoding selects which filtered edges raise an event.
package multi_edge_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  function automatic logic evt_sel(
    input mode_t m,
    input logic  rise,
    input logic  fall
  );
    logic w_r;
    logic w_f;
    w_r = (m == MODE_RISE) || (m == MODE_BOTH);
    w_f = (m == MODE_FALL) || (m == MODE_BOTH);
    return (rise & w_r) | (fall & w_f);
  endfunction

endpackage

// File: rtl/multi_edge_detect_chan.sv
// One channel: synchroniser, debounce filter, edge pulses,
// mode-gated event with sticky and overrun flags.
module edge_chan
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_sig,
  input  mode_t i_mode,
  input  logic  i_clr,
  output logic  o_pos,
  output logic  o_neg,
  output logic  o_evt,
  output logic  o_sticky,
  output logic  o_ovr
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEB_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;

  logic w_s;
  logic w_diff;
  logic w_flip;
  logic w_rise;
  logic w_fall;
  logic w_evt;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_filt;
  assign w_flip = w_diff && (r_cnt == CNT_LAST);
  assign w_rise = w_flip && !r_filt;
  assign w_fall = w_flip &&  r_filt;
  assign w_evt  = evt_sel(i_mode, w_rise, w_fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    end
  end

  // Counter only runs while the synchronised level disagrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (!w_diff) begin
      r_cnt  <= '0;
    end else if (w_flip) begin
      r_cnt  <= '0;
      r_filt <= ~r_filt;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pos <= 1'b0;
      o_neg <= 1'b0;
      o_evt <= 1'b0;
    end else begin
      o_pos <= w_rise;
      o_neg <= w_fall;
      o_evt <= w_evt;
    end
  end

  // A same-cycle event beats the clear; overrun is then left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sticky <= 1'b0;
      o_ovr    <= 1'b0;
    end else if (w_evt) begin
      o_sticky <= 1'b1;
      if (o_sticky && !i_clr) begin
        o_ovr <= 1'b1;
      end
    end else if (i_clr) begin
      o_sticky <= 1'b0;
      o_ovr    <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel debounced edge detector; one edge_chan
// per input, buses sliced per channel.
module multi_edge_detect
  import multi_edge_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   sig_in,
  input  logic [2*CH-1:0] mode_i,
  input  logic [CH-1:0]   clr_i,
  output logic [CH-1:0]   pos_pulse,
  output logic [CH-1:0]   neg_pulse,
  output logic [CH-1:0]   evt_pulse,
  output logic [CH-1:0]   evt_sticky,
  output logic [CH-1:0]   overrun
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    mode_t w_mode;
    assign w_mode = mode_t'(mode_i[2*i +: 2]);

    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT     (DEB_CNT)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_sig    (sig_in[i]),
      .i_mode   (w_mode),
      .i_clr    (clr_i[i]),
      .o_pos    (pos_pulse[i]),
      .o_neg    (neg_pulse[i]),
      .o_evt    (evt_pulse[i]),
      .o_sticky (evt_sticky[i]),
      .o_ovr    (overrun[i])
    );
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect with default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_multi_edge_detect;

  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   sig_in = '0;
  logic [2*CH-1:0] mode_i = '0;
  logic [CH-1:0]   clr_i = '0;
  logic [CH-1:0]   pos_pulse;
  logic [CH-1:0]   neg_pulse;
  logic [CH-1:0]   evt_pulse;
  logic [CH-1:0]   evt_sticky;
  logic [CH-1:0]   overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pos;
  int n_neg;

  always #5 clk = ~clk;

  multi_edge_detect #(
    .CH          (CH),
    .SYNC_STAGES (2),
    .DEB_CNT     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .mode_i     (mode_i),
    .clr_i      (clr_i),
    .pos_pulse  (pos_pulse),
    .neg_pulse  (neg_pulse),
    .evt_pulse  (evt_pulse),
    .evt_sticky (evt_sticky),
    .overrun    (overrun)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_pulses(input int n, input int ch);
    n_pos = 0;
    n_neg = 0;
    repeat (n) begin
      step(1);
      if (pos_pulse[ch]) n_pos++;
      if (neg_pulse[ch]) n_neg++;
    end
  endtask

  initial begin
    // Reset with all inputs high
    sig_in = 4'hF;
    step(3);
    chk("rst_pos", 32'(pos_pulse), 32'h0);
    chk("rst_neg", 32'(neg_pulse), 32'h0);
    chk("rst_evt", 32'(evt_pulse), 32'h0);
    chk("rst_sticky", 32'(evt_sticky), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;
    step(5);
    chk("rel_pos_e5", 32'(pos_pulse), 32'h0);
    step(1);
    chk("rel_pos_e6", 32'(pos_pulse), 32'hF);
    chk("rel_neg_e6", 32'(neg_pulse), 32'h0);
    chk("rel_evt_off", 32'(evt_pulse), 32'h0);
    step(1);
    chk("rel_pos_e7", 32'(pos_pulse), 32'h0);

    // Bring all channels back low
    sig_in = 4'h0;
    step(6);
    chk("fall_all_neg", 32'(neg_pulse), 32'hF);
    chk("fall_all_sticky", 32'(evt_sticky), 32'h0);
    step(4);

    // ch0 rise-only mode
    mode_i = 8'b0000_0001;
    sig_in[0] = 1'b1;
    step(5);
    chk("c0_pos_e5", 32'(pos_pulse[0]), 32'h0);
    step(1);
    chk("c0_pos_e6", 32'(pos_pulse[0]), 32'h1);
    chk("c0_evt_e6", 32'(evt_pulse[0]), 32'h1);
    chk("c0_sticky", 32'(evt_sticky[0]), 32'h1);
    step(1);
    chk("c0_pos_e7", 32'(pos_pulse[0]), 32'h0);
    chk("c0_evt_e7", 32'(evt_pulse[0]), 32'h0);
    step(3);
    sig_in[0] = 1'b0;
    step(6);
    chk("c0_neg", 32'(neg_pulse[0]), 32'h1);
    chk("c0_fall_noevt", 32'(evt_pulse[0]), 32'h0);
    chk("c0_fall_ovr", 32'(overrun[0]), 32'h0);
    clr_i[0] = 1'b1;
    step(1);
    clr_i[0] = 1'b0;
    chk("c0_clr_sticky", 32'(evt_sticky[0]), 32'h0);
    step(4);

    // ch1 glitch rejection then minimum-width pulse
    sig_in[1] = 1'b1;
    step(3);
    sig_in[1] = 1'b0;
    count_pulses(12, 1);
    chk("c1_glitch_pos", 32'(n_pos), 32'd0);
    chk("c1_glitch_neg", 32'(n_neg), 32'd0);
    sig_in[1] = 1'b1;
    step(4);
    sig_in[1] = 1'b0;
    count_pulses(16, 1);
    chk("c1_min_pos", 32'(n_pos), 32'd1);
    chk("c1_min_neg", 32'(n_neg), 32'd1);

    // ch2 both edges: sticky then overrun
    mode_i = 8'b0011_0000;
    sig_in[2] = 1'b1;
    step(6);
    chk("c2_evt1", 32'(evt_pulse[2]), 32'h1);
    chk("c2_sticky1", 32'(evt_sticky[2]), 32'h1);
    chk("c2_ovr1", 32'(overrun[2]), 32'h0);
    step(4);
    sig_in[2] = 1'b0;
    step(6);
    chk("c2_evt2", 32'(evt_pulse[2]), 32'h1);
    chk("c2_ovr2", 32'(overrun[2]), 32'h1);
    clr_i[2] = 1'b1;
    step(1);
    clr_i[2] = 1'b0;
    chk("c2_clr_sticky", 32'(evt_sticky[2]), 32'h0);
    chk("c2_clr_ovr", 32'(overrun[2]), 32'h0);
    step(4);

    // ch3 clear colliding with an event
    mode_i = 8'b1100_0000;
    sig_in[3] = 1'b1;
    step(6);
    chk("c3_sticky", 32'(evt_sticky[3]), 32'h1);
    step(4);
    sig_in[3] = 1'b0;
    step(5);
    clr_i[3] = 1'b1;
    step(1);
    clr_i[3] = 1'b0;
    chk("c3_coll_evt", 32'(evt_pulse[3]), 32'h1);
    chk("c3_coll_sticky", 32'(evt_sticky[3]), 32'h1);
    chk("c3_coll_ovr", 32'(overrun[3]), 32'h0);
    step(4);

    // Reset mid-debounce on ch0
    mode_i = 8'b0000_0001;
    sig_in[0] = 1'b1;
    step(4);
    rst = 1'b1;
    step(2);
    chk("mid_rst_pos", 32'(pos_pulse), 32'h0);
    chk("mid_rst_sticky", 32'(evt_sticky), 32'h0);
    rst = 1'b0;
    step(5);
    chk("mid_rel_e5", 32'(pos_pulse[0]), 32'h0);
    step(1);
    chk("mid_rel_e6", 32'(pos_pulse[0]), 32'h1);
    chk("mid_rel_evt", 32'(evt_pulse[0]), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
